// File: rtl/bitwise_ops_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_ops_pkg
// Brief    : Op-code encodings shared by the bitwise pipeline and its bus.
// Revision : 1.0 - initial release
// ============================================================================
package bitwise_ops_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd7;

endpackage
`default_nettype wire

// File: rtl/bitwise_ops_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_ops_pipe_if
// Brief    : Input/output valid-ready bus of the bitwise pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface bitwise_ops_pipe_if
  import bitwise_ops_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic             acc_mode;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             red_and;
  logic             red_or;
  logic             red_xor;
  logic [CNT_W-1:0] popcnt;

  modport master (
    output in_valid, op, acc_mode, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, y, red_and, red_or, red_xor, popcnt
  );

  modport slave (
    input  in_valid, op, acc_mode, acc_clr, a, b, out_ready,
    output in_ready, out_valid, y, red_and, red_or, red_xor, popcnt
  );

endinterface
`default_nettype wire

// File: rtl/bitwise_ops_pipe_popcount.sv
`default_nettype none
// ============================================================================
// Module   : bit_popcount
// Brief    : Combinational count of set bits in a WIDTH-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module bit_popcount #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic [WIDTH-1:0] i_bits,
  output logic      [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum = w_sum + CNT_W'(i_bits[i]);
    end
  end

  assign o_count = w_sum;

endmodule
`default_nettype wire

// File: rtl/bitwise_ops_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_ops_pipe
// Brief    : Two-stage elastic bitwise unit with accumulator and result flags.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_ops_pipe
  import bitwise_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  bitwise_ops_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_res;
  logic [CNT_W-1:0] w_cnt;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_y;
  logic [WIDTH-1:0] r_acc;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_red_and;
  logic             r_red_or;
  logic             r_red_xor;
  logic [CNT_W-1:0] r_popcnt;

  // Ready depends only on pipeline state, never on in_valid.
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = bus.in_valid && w_s1_adv;

  assign w_op_a = bus.acc_mode ? (bus.acc_clr ? '0 : r_acc) : bus.a;

  always_comb begin
    w_res = '0;
    case (bus.op)
      OP_AND:  w_res = w_op_a & bus.b;
      OP_OR:   w_res = w_op_a | bus.b;
      OP_XOR:  w_res = w_op_a ^ bus.b;
      OP_NAND: w_res = ~(w_op_a & bus.b);
      OP_NOR:  w_res = ~(w_op_a | bus.b);
      OP_XNOR: w_res = ~(w_op_a ^ bus.b);
      OP_NOT:  w_res = ~w_op_a;
      OP_ANDN: w_res = w_op_a & ~bus.b;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      if (bus.acc_mode) begin
        r_acc <= w_res;
      end else if (bus.acc_clr) begin
        r_acc <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_y <= w_res;
      end
    end
  end

  bit_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .i_bits  (r_s1_y),
    .o_count (w_cnt)
  );

  // Result registers only move on a real beat so a stalled output stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_red_and  <= 1'b0;
      r_red_or   <= 1'b0;
      r_red_xor  <= 1'b0;
      r_popcnt   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y       <= r_s1_y;
        r_red_and <= &r_s1_y;
        r_red_or  <= |r_s1_y;
        r_red_xor <= ^r_s1_y;
        r_popcnt  <= w_cnt;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.y         = r_y;
  assign bus.red_and   = r_red_and;
  assign bus.red_or    = r_red_or;
  assign bus.red_xor   = r_red_xor;
  assign bus.popcnt    = r_popcnt;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_ops_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_ops_pipe
// Brief    : Scoreboard bench for bitwise_ops_pipe (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_ops_pipe;
  import bitwise_ops_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitwise_ops_pipe_if #(.WIDTH(WIDTH)) bus ();

  bitwise_ops_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_beats  = 0;
  logic [7:0] sb[$];
  logic [7:0] m_acc;
  logic       prev_stall;
  logic [7:0] prev_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a & ~b;
    endcase
  endfunction

  function automatic int ref_pop(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  // Monitor: all handshakes are decided by the values seen here, since inputs
  // only change just after the rising edge.
  always @(negedge clk) begin
    logic [7:0] ea;
    logic [7:0] er;
    int         pc;
    if (rst) begin
      sb.delete();
      m_acc      = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_y", bus.y, prev_y);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", sb.size(), 1);
        end else begin
          er = sb.pop_front();
          pc = ref_pop(er);
          check("sb_y", bus.y, er);
          check("sb_popcnt", bus.popcnt, pc);
          check("sb_red_and", bus.red_and, (pc == 8) ? 1 : 0);
          check("sb_red_or", bus.red_or, (pc != 0) ? 1 : 0);
          check("sb_red_xor", bus.red_xor, pc % 2);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        ea = bus.acc_mode ? (bus.acc_clr ? 8'h00 : m_acc) : bus.a;
        er = ref_op(bus.op, ea, bus.b);
        if (bus.acc_mode)     m_acc = er;
        else if (bus.acc_clr) m_acc = '0;
        sb.push_back(er);
        n_beats++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.y;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic am, input logic ac);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc_mode = am;
    bus.acc_clr  = ac;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      sync();
      if (ok) break;
    end
    check("accept_within_bound", ok, 1);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic am, input logic ac);
    drive(op, a, b, am, ac);
    wait_accept();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.acc_mode = 1'b0;
    bus.acc_clr  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int guard;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.acc_mode  = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    sync();
    sample();
    check("rst_out_valid_during", bus.out_valid, 0);
    repeat (2) sync();
    rst = 1'b0;
    sample();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    check("rst_popcnt", bus.popcnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    sync();

    // 1: single AND, two-stage latency
    send(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
    idle();
    sample();
    check("t1_not_early", bus.out_valid, 0);
    sample();
    check("t1_valid", bus.out_valid, 1);
    check("t1_y", bus.y, 8'h30);
    check("t1_popcnt", bus.popcnt, 2);
    check("t1_red_or", bus.red_or, 1);
    check("t1_red_and", bus.red_and, 0);
    check("t1_red_xor", bus.red_xor, 0);
    sync();

    // 2: back-to-back NOT / XNOR
    send(OP_NOT, 8'h00, 8'h5A, 1'b0, 1'b0);
    send(OP_XNOR, 8'hA5, 8'hA5, 1'b0, 1'b0);
    idle();
    sample();
    check("t2_first_valid", bus.out_valid, 1);
    check("t2_first_y", bus.y, 8'hFF);
    check("t2_first_popcnt", bus.popcnt, 8);
    check("t2_first_red_and", bus.red_and, 1);
    sample();
    check("t2_second_valid", bus.out_valid, 1);
    check("t2_second_y", bus.y, 8'hFF);
    sync();

    // 3: accumulate chain
    send(OP_XOR, 8'h77, 8'h0F, 1'b1, 1'b1);
    send(OP_XOR, 8'h77, 8'hFF, 1'b1, 1'b0);
    send(OP_XOR, 8'h77, 8'hF0, 1'b1, 1'b0);
    idle();
    sample();
    check("t3_second_y", bus.y, 8'hF0);
    sample();
    check("t3_third_y", bus.y, 8'h00);
    check("t3_third_red_or", bus.red_or, 0);
    check("t3_third_popcnt", bus.popcnt, 0);
    sync();
    send(OP_OR, 8'h00, 8'h81, 1'b1, 1'b0);
    idle();
    sample();
    sample();
    check("t3_acc_zero", bus.y, 8'h81);
    sync();

    // 4: backpressure
    bus.out_ready = 1'b0;
    drive(OP_OR, 8'h01, 8'h00, 1'b0, 1'b0);
    sync();
    drive(OP_OR, 8'h02, 8'h00, 1'b0, 1'b0);
    sync();
    drive(OP_OR, 8'h04, 8'h00, 1'b0, 1'b0);
    sample();
    check("t4_in_ready_low", bus.in_ready, 0);
    check("t4_out_valid", bus.out_valid, 1);
    check("t4_y_held", bus.y, 8'h01);
    check("t4_sb_depth", sb.size(), 2);
    sync();
    sync();
    sample();
    check("t4_in_ready_still_low", bus.in_ready, 0);
    check("t4_y_still", bus.y, 8'h01);
    sync();
    bus.out_ready = 1'b1;
    wait_accept();
    idle();
    repeat (5) sync();
    check("t4_drained", sb.size(), 0);

    // 5: reset with beats in flight
    send(OP_XOR, 8'h00, 8'h3C, 1'b1, 1'b1);
    send(OP_OR, 8'h11, 8'h22, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    sample();
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_y", bus.y, 0);
    check("t5_popcnt", bus.popcnt, 0);
    check("t5_red_or", bus.red_or, 0);
    sync();
    send(OP_ANDN, 8'hFF, 8'h0F, 1'b0, 1'b0);
    send(OP_XOR, 8'hFF, 8'h5A, 1'b1, 1'b0);
    idle();
    sample();
    check("t5_andn_valid", bus.out_valid, 1);
    check("t5_andn_y", bus.y, 8'hF0);
    sample();
    check("t5_acc_cleared", bus.y, 8'h5A);
    sync();

    // 6: random traffic against the model
    start = n_beats;
    guard = 0;
    while ((n_beats - start) < 1000 && guard < 20000) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.op        = 3'($urandom_range(7));
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.acc_mode  = ($urandom_range(2) == 0);
      bus.acc_clr   = ($urandom_range(7) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      sync();
      guard++;
    end
    check("t6_beats", ((n_beats - start) >= 1000) ? 1 : 0, 1);
    idle();
    bus.out_ready = 1'b1;
    repeat (6) sync();
    check("t6_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
